// File: rtl/mtimer_ctrl.sv
// -----------------------------------------------------------------------------
// mtimer_ctrl
//
// Machine timer peripheral. It keeps a free-running 64-bit mtime counter,
// advanced by a programmable prescaler, and a 64-bit mtimecmp compare
// register. All of them sit on a simple single-cycle register bus. The
// timer interrupt is a registered level that stays high while
// mtime >= mtimecmp.
//
// Ports
//   clk_i        : clock; all state updates on the rising edge
//   rst_i        : asynchronous reset, active low
//   sel_i        : bus access request; one access per cycle high
//   wr_en_i      : 1 = write, 0 = read (qualified by sel_i)
//   addr_i       : byte offset; bits [1:0] are ignored
//   wdata_i      : write data
//   rdata_o      : read data; valid while ready_o is high, 0 otherwise
//   ready_o      : access completion, one cycle after sel_i
//   int_timer_o  : machine timer interrupt (registered level)
//
// Register map (byte offsets)
//   0x00 MTIME_LO     RW
//   0x04 MTIME_HI     RW (reads return the shadow captured by a LO read)
//   0x08 MTIMECMP_LO  RW
//   0x0C MTIMECMP_HI  RW
//   0x10 CTRL         RW  bit 0 = EN, bits [8+DIV_W-1:8] = DIV
//   0x14-0x1C         unmapped: read 0, writes ignored
//
// DIV_W must not exceed 24 so that the DIV field fits in the CTRL word.
// -----------------------------------------------------------------------------
module mtimer_ctrl #(
    parameter int unsigned DIV_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic        wr_en_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        int_timer_o
);

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4
    } reg_idx_e;

    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
    localparam logic [63:0]      MTIME_ONE = 64'd1;

    // Architectural state
    logic [63:0]      mtime_q,    mtime_d;
    logic [31:0]      shadow_q,   shadow_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             en_q,       en_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [DIV_W-1:0] pre_cnt_q,  pre_cnt_d;

    // Bus response and interrupt registers
    logic             ready_q,    ready_d;
    logic [31:0]      rdata_q,    rdata_d;
    logic             int_q,      int_d;

    reg_idx_e         reg_idx;
    logic             wr_acc;
    logic             rd_acc;
    logic             tick;
    logic [31:0]      ctrl_rd;
    logic [31:0]      rd_val;
    logic [1:0]       unused_addr;

    // Word index only; byte lanes within a word are not decoded.
    assign reg_idx     = reg_idx_e'(addr_i[4:2]);
    assign unused_addr = addr_i[1:0];
    assign wr_acc      = sel_i & wr_en_i;
    assign rd_acc      = sel_i & ~wr_en_i;

    // One tick per DIV+1 enabled cycles.
    assign tick = en_q && (pre_cnt_q == div_q);

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[0]           = en_q;
        ctrl_rd[8 +: DIV_W]  = div_q;
    end

    // Read mux works on pre-edge values, so a LO read that coincides with a
    // tick returns the value before the increment.
    always_comb begin
        rd_val = '0;
        unique case (reg_idx)
            REG_MTIME_LO:    rd_val = mtime_q[31:0];
            REG_MTIME_HI:    rd_val = shadow_q;
            REG_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            REG_CTRL:        rd_val = ctrl_rd;
            default:         rd_val = '0;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mtime_d    = mtime_q;
        shadow_d   = shadow_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        div_d      = div_q;
        pre_cnt_d  = pre_cnt_q;

        // Prescale counter: free-runs while enabled, cleared by CTRL writes.
        if (en_q) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + CNT_ONE;
        end

        // A bus write to either mtime half wins over the tick and replaces
        // only that half, with no carry into the other half.
        if (wr_acc && reg_idx == REG_MTIME_LO) begin
            mtime_d = {mtime_q[63:32], wdata_i};
        end else if (wr_acc && reg_idx == REG_MTIME_HI) begin
            mtime_d = {wdata_i, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + MTIME_ONE;
        end

        // Shadow gives software a coherent 64-bit snapshot: LO read captures
        // the high half, HI read returns the captured value.
        if (wr_acc && reg_idx == REG_MTIME_HI) begin
            shadow_d = wdata_i;
        end else if (rd_acc && reg_idx == REG_MTIME_LO) begin
            shadow_d = mtime_q[63:32];
        end

        if (wr_acc && reg_idx == REG_MTIMECMP_LO) begin
            mtimecmp_d[31:0] = wdata_i;
        end
        if (wr_acc && reg_idx == REG_MTIMECMP_HI) begin
            mtimecmp_d[63:32] = wdata_i;
        end

        if (wr_acc && reg_idx == REG_CTRL) begin
            en_d      = wdata_i[0];
            div_d     = wdata_i[8 +: DIV_W];
            pre_cnt_d = '0;
        end
    end

    assign ready_d = sel_i;
    assign rdata_d = rd_acc ? rd_val : '0;
    assign int_d   = (mtime_q >= mtimecmp_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime_q    <= '0;
            shadow_q   <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b1;
            div_q      <= '0;
            pre_cnt_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            int_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            shadow_q   <= shadow_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            div_q      <= div_d;
            pre_cnt_q  <= pre_cnt_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            int_q      <= int_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign ready_o     = ready_q;
    assign int_timer_o = int_q;

endmodule

// File: tb/tb_mtimer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mtimer_ctrl
//
// Bench for mtimer_ctrl. A behavioural model holds mtime, mtimecmp, the
// shadow and the control fields as plain variables. The tick is derived from
// the number of enabled cycles since the last CTRL write. A compare process
// checks ready_o, rdata_o and int_timer_o against the model on every falling
// edge. Directed scenarios also pin a few hand-computed values, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_mtimer_ctrl;

    localparam int DIV_W = 8;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    mtimer_ctrl #(.DIV_W(DIV_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .sel_i       (sel),
        .wr_en_i     (wr_en),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .ready_o     (ready),
        .int_timer_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    logic [63:0]      m_mtime;
    logic [63:0]      m_cmp;
    logic [31:0]      m_shadow;
    logic             m_en;
    logic [DIV_W-1:0] m_div;
    int unsigned      m_k;      // enabled cycles since the last CTRL write
    logic             m_ready;
    logic [31:0]      m_rdata;
    logic             m_int;

    wire [2:0] w_idx  = addr[4:2];
    wire       do_wr  = sel & wr_en;
    wire       do_rd  = sel & ~wr_en;

    function automatic bit m_tick(input logic en, input logic [DIV_W-1:0] dv,
                                  input int unsigned k);
        int unsigned period;
        period = int'(dv) + 1;
        return en && ((k % period) == int'(dv));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] w);
        case (w)
            3'd0:    return m_mtime[31:0];
            3'd1:    return m_shadow;
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return (32'(m_div) << 8) | 32'(m_en);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime  <= 64'h0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_shadow <= 32'h0;
            m_en     <= 1'b1;
            m_div    <= '0;
            m_k      <= 0;
            m_ready  <= 1'b0;
            m_rdata  <= 32'h0;
            m_int    <= 1'b0;
        end else begin
            m_ready <= sel;
            m_rdata <= do_rd ? m_read(w_idx) : 32'h0;
            m_int   <= (m_mtime >= m_cmp);

            if (do_wr && w_idx == 3'd0)
                m_mtime <= {m_mtime[63:32], wdata};
            else if (do_wr && w_idx == 3'd1)
                m_mtime <= {wdata, m_mtime[31:0]};
            else if (m_tick(m_en, m_div, m_k))
                m_mtime <= m_mtime + 64'd1;

            if (do_wr && w_idx == 3'd1)
                m_shadow <= wdata;
            else if (do_rd && w_idx == 3'd0)
                m_shadow <= m_mtime[63:32];

            if (do_wr && w_idx == 3'd2) m_cmp[31:0]  <= wdata;
            if (do_wr && w_idx == 3'd3) m_cmp[63:32] <= wdata;

            if (do_wr && w_idx == 3'd4) begin
                m_en  <= wdata[0];
                m_div <= wdata[8 +: DIV_W];
                m_k   <= 0;
            end else if (m_en) begin
                m_k <= m_k + 1;
            end
        end
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ready_o", 64'(ready), 64'(m_ready));
        check("rdata_o", 64'(rdata), 64'(m_rdata));
        check("int_timer_o", 64'(irq), 64'(m_int));
    end

    // ------------------------------------------------------------ bus tasks
    // Each task starts and ends on a falling edge; sel stays high on return
    // so accesses chain back-to-back.
    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        sel = 1'b1; wr_en = 1'b0; addr = a; wdata = 32'h0;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic idle(input int n);
        sel = 1'b0; wr_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] d;
        int          n;
        logic [2:0]  w;

        sel = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ready_o", 64'(ready), 64'h0);
        check("reset rdata_o", 64'(rdata), 64'h0);
        check("reset int", 64'(irq), 64'h0);

        // Reset release followed by ten edges; DIV = 0 so each edge ticks.
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(5'h00, d); check("idle mtime_lo", 64'(d), 64'd10);
        bus_rd(5'h04, d); check("idle mtime_hi", 64'(d), 64'd0);
        bus_rd(5'h0C, d); check("reset mtimecmp_hi", 64'(d), 64'hFFFF_FFFF);
        bus_rd(5'h10, d); check("reset ctrl", 64'(d), 64'h1);
        check("idle int low", 64'(irq), 64'h0);

        // Prescaler DIV = 3: one tick every fourth edge.
        bus_wr(5'h10, 32'h0000_0301);
        bus_wr(5'h00, 32'h0);
        bus_wr(5'h04, 32'h0);
        idle(40);
        bus_rd(5'h00, d); check("div3 mtime", 64'(d), 64'd10);
        bus_wr(5'h10, 32'h0000_0300);           // EN = 0
        idle(20);
        bus_rd(5'h00, d); check("disabled mtime a", 64'(d), 64'd11);
        idle(20);
        bus_rd(5'h00, d); check("disabled mtime b", 64'(d), 64'd11);

        // Carry from low into high half.
        bus_wr(5'h10, 32'h0000_0001);
        bus_wr(5'h04, 32'h0);
        bus_wr(5'h00, 32'hFFFF_FFFE);
        idle(3);
        bus_rd(5'h00, d); check("carry lo", 64'(d), 64'd1);
        bus_rd(5'h04, d); check("carry hi", 64'(d), 64'd1);

        // Interrupt rises one edge after mtime reaches mtimecmp.
        bus_wr(5'h0C, 32'h0);
        bus_wr(5'h08, 32'd100);
        bus_wr(5'h04, 32'h0);
        bus_wr(5'h00, 32'd90);
        sel = 1'b0; wr_en = 1'b0;
        n = 0;
        while (n <= 50) begin
            @(negedge clk);
            n++;
            if (irq) break;
        end
        check("int rise latency", 64'(n), 64'd11);
        bus_wr(5'h08, 32'd1000);
        check("int held on cmp write edge", 64'(irq), 64'h1);
        idle(1);
        check("int falls after cmp raise", 64'(irq), 64'h0);

        // Atomic read across a carry.
        bus_wr(5'h04, 32'h0);
        bus_wr(5'h00, 32'hFFFF_FFFF);
        bus_rd(5'h00, d); check("atomic lo", 64'(d), 64'hFFFF_FFFF);
        bus_rd(5'h04, d); check("atomic hi", 64'(d), 64'h0);

        // Unmapped word.
        bus_wr(5'h18, 32'hDEAD_BEEF);
        bus_rd(5'h18, d);
        check("unmapped rdata", 64'(d), 64'h0);
        check("unmapped ready", 64'(ready), 64'h1);

        // Asynchronous reset with an access in flight and the interrupt high.
        bus_wr(5'h08, 32'h0);
        bus_wr(5'h0C, 32'h0);
        idle(2);
        check("int before reset", 64'(irq), 64'h1);
        sel = 1'b1; wr_en = 1'b0; addr = 5'h00;
        @(posedge clk);
        #2;
        check("ready before reset", 64'(ready), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async reset ready", 64'(ready), 64'h0);
        check("async reset int", 64'(irq), 64'h0);
        @(negedge clk);
        sel = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic, stimulus biased toward interesting values.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                sel = 1'b0;
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            w     = 3'($urandom_range(0, 7));
            sel   = ($urandom_range(0, 3) != 0);
            wr_en = ($urandom_range(0, 2) == 0);
            addr  = {w, 2'($urandom)};
            case (w)
                3'd0: wdata = ($urandom_range(0, 3) == 0) ? $urandom
                              : 32'hFFFF_FFFF - $urandom_range(0, 20);
                3'd1: wdata = $urandom_range(0, 3);
                3'd2: wdata = m_mtime[31:0] + $urandom_range(0, 30);
                3'd3: wdata = m_mtime[63:32] + $urandom_range(0, 1);
                3'd4: wdata = ($urandom_range(0, 7) == 0) ? $urandom
                              : (($urandom_range(0, 3) << 8) |
                                 32'($urandom_range(0, 4) != 0));
                default: wdata = $urandom;
            endcase
            @(negedge clk);
        end
        idle(2);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
